// File: rtl/nand_cmd_addr_seq_if.sv
// -----------------------------------------------------------------------------
// nand_cmd_addr_seq_if
// Groups the request side and the NAND pin side of nand_cmd_addr_seq.
//
// Request handshake: start_i is a request pulse. It is sampled only while
// busy_o=0, which covers idle and the one-cycle done_o slot. A request seen
// while busy_o=1 is dropped. cmd_i, cmd2_i, addr_i and addr_cycles_i need to
// be valid only in the cycle where start_i is accepted.
//
//   master : drives the request, observes the NAND pins (testbench / host)
//   slave  : the sequencer itself
//
//   start_i        request pulse
//   cmd_i[7:0]     first command byte
//   cmd2_i[7:0]    confirm command byte (used only with NAND_CONFIRM_CMD_EN)
//   addr_i[31:0]   address bytes, addr_i[7:0] goes out first
//   addr_cycles_i  number of address bytes (values above 4 mean 4)
//   busy_o         sequence in progress
//   done_o         one-cycle completion pulse
//   ce_n_o, cle_o, ale_o, we_n_o, io_o[7:0], io_oe_o   NAND pins
//   state_o[2:0]   current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
interface nand_cmd_addr_seq_if;
    logic        start_i;
    logic [7:0]  cmd_i;
    logic [7:0]  cmd2_i;
    logic [31:0] addr_i;
    logic [2:0]  addr_cycles_i;
    logic        busy_o;
    logic        done_o;
    logic        ce_n_o;
    logic        cle_o;
    logic        ale_o;
    logic        we_n_o;
    logic [7:0]  io_o;
    logic        io_oe_o;
    logic [2:0]  state_o;

    modport master (
        output start_i, cmd_i, cmd2_i, addr_i, addr_cycles_i,
        input  busy_o, done_o, ce_n_o, cle_o, ale_o, we_n_o, io_o, io_oe_o, state_o
    );

    modport slave (
        input  start_i, cmd_i, cmd2_i, addr_i, addr_cycles_i,
        output busy_o, done_o, ce_n_o, cle_o, ale_o, we_n_o, io_o, io_oe_o, state_o
    );
endinterface

// File: rtl/nand_cmd_addr_seq.sv
// -----------------------------------------------------------------------------
// nand_cmd_addr_seq
// Emits a NAND command / address latch sequence: one command byte, 0..4
// address bytes (LSB first) and, when NAND_CONFIRM_CMD_EN is defined, one
// confirm command byte. Each byte occupies one latch cycle:
//   1 setup cycle (we_n=1), TWP cycles we_n=0, TWH cycles we_n=1,
// with cle/ale/io/io_oe held constant for the whole latch cycle.
//
// Optional feature macro: NAND_CONFIRM_CMD_EN (adds the CMD2 confirm phase).
//
// Parameters
//   TWP  we_n low cycles per latch cycle, 1..15
//   TWH  we_n high (hold) cycles per latch cycle, 1..15
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  nand_cmd_addr_seq_if.slave (request inputs, NAND pins, debug state)
//
// Every output comes straight from a register; the next-state logic computes
// the value each pin must have in the following cycle.
// -----------------------------------------------------------------------------
module nand_cmd_addr_seq #(
    parameter int TWP = 2,
    parameter int TWH = 1
) (
    input  logic                clk,
    input  logic                rst,
    nand_cmd_addr_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
`ifdef NAND_CONFIRM_CMD_EN
        S_CMD2 = 3'd3,
`endif
        S_DONE = 3'd4
    } state_t;

    // Phase counter runs 0 (setup) .. TWP (last low) .. TWP+TWH (last high).
    localparam logic [4:0] TWP_C  = 5'(TWP);
    localparam logic [4:0] LAST_C = 5'(TWP + TWH);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  addr_left_q, addr_left_d;   // address bytes still to send
    logic [31:0] addr_q, addr_d;             // shifts right one byte per ADDR cycle
    logic [7:0]  cmd_q, cmd_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ce_n_q, ce_n_d;
    logic        cle_q, cle_d;
    logic        ale_q, ale_d;
    logic        we_n_q, we_n_d;
    logic [7:0]  io_q, io_d;
    logic        io_oe_q, io_oe_d;

    logic [2:0]  eff_cycles;
    logic [4:0]  cnt_inc;
    logic        latch_end;
    logic        accept;
    logic        next_byte;
    logic        finish_addr;
    logic        enter_done;

`ifdef NAND_CONFIRM_CMD_EN
    logic [7:0]  cmd2_q, cmd2_d;
    logic        enter_cmd2;
`else
    logic        unused_cmd2;
    assign unused_cmd2 = ^bus.cmd2_i;
`endif

    assign eff_cycles = (bus.addr_cycles_i > 3'd4) ? 3'd4 : bus.addr_cycles_i;
    assign cnt_inc    = cnt_q + 5'd1;
    assign latch_end  = (cnt_q == LAST_C);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_left_d = addr_left_q;
        addr_d      = addr_q;
        cmd_d       = cmd_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ce_n_d      = ce_n_q;
        cle_d       = cle_q;
        ale_d       = ale_q;
        we_n_d      = we_n_q;
        io_d        = io_q;
        io_oe_d     = io_oe_q;
        accept      = 1'b0;
        next_byte   = 1'b0;
        finish_addr = 1'b0;
        enter_done  = 1'b0;
`ifdef NAND_CONFIRM_CMD_EN
        cmd2_d      = cmd2_q;
        enter_cmd2  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                accept = bus.start_i;
            end
            S_DONE: begin
                // A request held through DONE restarts without an idle gap.
                accept = bus.start_i;
                if (!bus.start_i) begin
                    state_d = S_IDLE;
                end
            end
            S_CMD, S_ADDR: begin
                cnt_d  = cnt_inc;
                we_n_d = (cnt_inc <= TWP_C) ? 1'b0 : 1'b1;
                if (latch_end) begin
                    if (addr_left_q != 3'd0) begin
                        next_byte = 1'b1;
                    end else begin
                        finish_addr = 1'b1;
                    end
                end
            end
`ifdef NAND_CONFIRM_CMD_EN
            S_CMD2: begin
                cnt_d  = cnt_inc;
                we_n_d = (cnt_inc <= TWP_C) ? 1'b0 : 1'b1;
                if (latch_end) begin
                    enter_done = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef NAND_CONFIRM_CMD_EN
        if (finish_addr) begin
            enter_cmd2 = 1'b1;
        end
`else
        if (finish_addr) begin
            enter_done = 1'b1;
        end
`endif

        if (accept) begin
            state_d     = S_CMD;
            cnt_d       = 5'd0;
            cmd_d       = bus.cmd_i;
            addr_d      = bus.addr_i;
            addr_left_d = eff_cycles;
            busy_d      = 1'b1;
            ce_n_d      = 1'b0;
            cle_d       = 1'b1;
            ale_d       = 1'b0;
            we_n_d      = 1'b1;
            io_d        = bus.cmd_i;
            io_oe_d     = 1'b1;
`ifdef NAND_CONFIRM_CMD_EN
            cmd2_d      = bus.cmd2_i;
`endif
        end

        if (next_byte) begin
            state_d     = S_ADDR;
            cnt_d       = 5'd0;
            we_n_d      = 1'b1;
            cle_d       = 1'b0;
            ale_d       = 1'b1;
            io_d        = addr_q[7:0];
            addr_d      = {8'h00, addr_q[31:8]};
            addr_left_d = addr_left_q - 3'd1;
        end

`ifdef NAND_CONFIRM_CMD_EN
        if (enter_cmd2) begin
            state_d = S_CMD2;
            cnt_d   = 5'd0;
            we_n_d  = 1'b1;
            cle_d   = 1'b1;
            ale_d   = 1'b0;
            io_d    = cmd2_q;
        end
`endif

        if (enter_done) begin
            // io keeps the last byte sent; only the drive enable drops.
            state_d = S_DONE;
            cnt_d   = 5'd0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ce_n_d  = 1'b1;
            cle_d   = 1'b0;
            ale_d   = 1'b0;
            we_n_d  = 1'b1;
            io_oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            addr_left_q <= 3'd0;
            addr_q      <= 32'h0;
            cmd_q       <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ce_n_q      <= 1'b1;
            cle_q       <= 1'b0;
            ale_q       <= 1'b0;
            we_n_q      <= 1'b1;
            io_q        <= 8'h00;
            io_oe_q     <= 1'b0;
`ifdef NAND_CONFIRM_CMD_EN
            cmd2_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_left_q <= addr_left_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ce_n_q      <= ce_n_d;
            cle_q       <= cle_d;
            ale_q       <= ale_d;
            we_n_q      <= we_n_d;
            io_q        <= io_d;
            io_oe_q     <= io_oe_d;
`ifdef NAND_CONFIRM_CMD_EN
            cmd2_q      <= cmd2_d;
`endif
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.ce_n_o  = ce_n_q;
    assign bus.cle_o   = cle_q;
    assign bus.ale_o   = ale_q;
    assign bus.we_n_o  = we_n_q;
    assign bus.io_o    = io_q;
    assign bus.io_oe_o = io_oe_q;
    assign bus.state_o = state_q;

endmodule

// File: doc/nand_cmd_addr_seq.md
NAND_CMD_ADDR_SEQ -- requirements
Module: nand_cmd_addr_seq

Interface
- REQ-001: Parameter TWP, default 2: we_n low time per latch cycle, in clk cycles; legal range 1..15.
- REQ-002: Parameter TWH, default 1: we_n high (hold) time per latch cycle, in clk cycles; legal range 1..15.
- REQ-003: clk  input  1  single clock; all sequential logic is on the rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: start  input  1  request pulse; sampled only while busy=0.
- REQ-006: cmd  input  8  first command byte; captured on start acceptance.
- REQ-007: cmd2  input  8  confirm command byte; captured on start; used only under NAND_CONFIRM_CMD_EN.
- REQ-008: addr  input  32  address bytes, with addr[7:0] sent first; captured on start.
- REQ-009: addr_cycles  input  3  number of address bytes, 0..4; captured on start.
- REQ-010: busy  output  1  sequence in progress.
- REQ-011: done  output  1  one-cycle completion pulse.
- REQ-012: ce_n  output  1  NAND chip enable, active low.
- REQ-013: cle  output  1  command latch enable.
- REQ-014: ale  output  1  address latch enable.
- REQ-015: we_n  output  1  write enable strobe, active low.
- REQ-016: io  output  8  NAND IO bus data.
- REQ-017: io_oe  output  1  IO bus drive enable.

Function
- REQ-018: States SHALL be IDLE, CMD, ADDR, CMD2 (only under NAND_CONFIRM_CMD_EN) and DONE.
- REQ-019: Latch cycle definition: 1 setup cycle (we_n=1), then TWP cycles with we_n=0, then TWH cycles with we_n=1; cle, ale, io and io_oe stay stable for the whole latch cycle.
- REQ-020: start=1 in IDLE or DONE is accepted. The cycle after acceptance: busy=1, ce_n=0, cle=1, ale=0, io=cmd, io_oe=1, state CMD.
- REQ-021: start while busy=1 SHALL be ignored; captured operands SHALL NOT change.
- REQ-022: CMD→ADDR after its latch cycle if addr_cycles≠0; otherwise CMD→CMD2 (macro on) or CMD→DONE.
- REQ-023: ADDR runs one latch cycle per byte (cle=0, ale=1); byte k SHALL be addr[8k+7:8k], k=0..N-1.
- REQ-024: addr_cycles values 5..7 SHALL be treated as 4.
- REQ-025: ADDR→CMD2 (macro on) or ADDR→DONE after the last byte.
- REQ-026: DONE lasts one cycle: done=1, busy=0, ce_n=1, cle=0, ale=0, we_n=1, io_oe=0, io holds its last value; next state IDLE, or CMD if start=1.
- REQ-027: Latency: total busy time = (1+A+C2)×(1+TWP+TWH) cycles, where A=effective addr_cycles and C2=1 if CMD2 is compiled in, else 0. done asserts in the following cycle.
- REQ-028: Outputs SHALL be driven directly from registers, with no combinational path from any input.

Reset
- REQ-029: rst=1 SHALL immediately force IDLE with busy=0, done=0, ce_n=1, cle=0, ale=0, we_n=1, io=8'h00, io_oe=0, including during an active sequence.
- REQ-030: After rst deasserts, the first start SHALL be accepted on the next rising edge at which it is sampled high.

Configuration
- REQ-031: Macro NAND_CONFIRM_CMD_EN defined: after the address phase, one CMD2 latch cycle SHALL follow (cle=1, ale=0, io=cmd2).
- REQ-032: NAND_CONFIRM_CMD_EN undefined: the CMD2 state and cmd2 usage are absent; the cmd2 port remains present but ignored.

Verification
- REQ-033: Defaults, macro off, cmd=8'h90, addr_cycles=1, addr=32'h00 → two latch cycles (cle then ale), done exactly 8 cycles after the acceptance edge+1, io sequence 90,00.
- REQ-034: Defaults, macro on, cmd=8'h00, cmd2=8'h30, addr_cycles=4, addr=32'h44332211 → io sequence 00,11,22,33,44,30; each we_n low for 2 cycles; done 24 cycles after start+1.
- REQ-035: addr_cycles=7 → exactly 4 ale cycles; addr_cycles=0 → no ale pulse at all.
- REQ-036: start re-pulsed with different cmd while busy → ignored; io shows only the original bytes. start held high during DONE → new sequence begins with no IDLE gap.
- REQ-037: rst asserted during the we_n-low phase of address byte 2 → same-cycle return to reset values; a fresh start afterwards completes normally.
